// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, flag bundle and popcount helper
package alu_pkg;
  localparam int ALU_WIDTH = 4;
  localparam int MAX_W = 32;
  localparam int MAX_POPW = 6;
  typedef struct packed {
    logic zero;
    logic ones;
    logic [MAX_POPW-1:0] pop;
  } alu_flags_t;
  function automatic logic [MAX_POPW-1:0] popcount(input logic [MAX_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_W; i++) popcount += MAX_POPW'(v[i]);
  endfunction
endpackage

// File: rtl/and_core.sv
// and_core: combinational bitwise AND with zero/all-ones/popcount flags
module and_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output alu_flags_t       flags
);
  // result and flags derived from the same AND so they always agree
  always_comb begin
    y = a & b;
    flags = '{zero: (y == '0), ones: (&y), pop: popcount(MAX_W'(y))};
  end
endmodule

// File: rtl/and4_unit.sv
// and4_unit: registered AND stage with valid/ready handshake and status flags
module and4_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int POPW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             y_ones,
  output logic [POPW-1:0]  y_pop,
  output logic             out_valid,
  input  logic             out_ready
);
  logic [WIDTH-1:0] c_y;
  alu_flags_t c_f;
  logic accept;
  logic pop_unused;
  and_core #(.WIDTH(WIDTH)) u_core (.a(a), .b(b), .y(c_y), .flags(c_f));
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign pop_unused = ^(c_f.pop >> POPW);
  // capture result and flags together on accept; otherwise only drop valid on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y <= '0;
      y_zero <= 1'b1;
      y_ones <= 1'b0;
      y_pop <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y <= c_y;
      y_zero <= c_f.zero;
      y_ones <= c_f.ones;
      y_pop <= c_f.pop[POPW-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_and4_unit.sv
// tb_and4_unit: randomized and directed checks of and4_unit against a queue model
module tb_and4_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, y_zero, y_ones, out_valid;
  logic [3:0] y;
  logic [2:0] y_pop;
  int checks = 0, errors = 0;
  int n_acc = 0, n_cons = 0;
  logic [3:0] q[$];
  logic [3:0] m_y = '0;

  and4_unit dut (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .in_ready(in_ready), .y(y), .y_zero(y_zero), .y_ones(y_ones), .y_pop(y_pop),
    .out_valid(out_valid), .out_ready(out_ready));

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  // every cycle out of reset, outputs must reflect the held result of the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("y", int'(y), int'(m_y));
      chk("y_zero", int'(y_zero), int'(m_y == 4'b0000));
      chk("y_ones", int'(y_ones), int'(m_y == 4'b1111));
      chk("y_pop", int'(y_pop), $countones(m_y));
    end
  end

  // one cycle: drive at negedge, predict the edge, advance to next negedge
  task automatic cyc(input logic [3:0] va, input logic [3:0] vb, input logic iv, input logic orr);
    bit acc, cons;
    a = va; b = vb; in_valid = iv; out_ready = orr;
    #1;
    chk("in_ready", int'(in_ready), int'(q.size() == 0 || orr));
    cons = q.size() != 0 && orr;
    acc = iv && (q.size() == 0 || orr);
    if (cons) begin
      chk("order", int'(y), int'(q[0]));
      void'(q.pop_front());
      n_cons++;
    end
    @(posedge clk);
    if (acc) begin
      q.push_back(va & vb);
      m_y = va & vb;
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic vec(input string n, input logic [3:0] va, input logic [3:0] vb,
                     input int ey, input int ez, input int eo, input int ep);
    cyc(va, vb, 1'b1, 1'b1);
    chk({n, "_y"}, int'(y), ey);
    chk({n, "_zero"}, int'(y_zero), ez);
    chk({n, "_ones"}, int'(y_ones), eo);
    chk({n, "_pop"}, int'(y_pop), ep);
  endtask

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_zero", int'(y_zero), 1);
    chk("rst_pop", int'(y_pop), 0);
    rst_n = 1'b1;
    @(negedge clk);
    vec("v1111", 4'b1111, 4'b1111, 15, 0, 1, 4);
    vec("v1010", 4'b1010, 4'b1100, 8, 0, 0, 1);
    vec("v0110", 4'b0110, 4'b1001, 0, 1, 0, 0);
    vec("vf0", 4'b1111, 4'b0000, 0, 1, 0, 0);
    vec("v0f", 4'b0000, 4'b1111, 0, 1, 0, 0);
    vec("v0101", 4'b0101, 4'b0011, 1, 0, 0, 1);
    cyc(4'b0, 4'b0, 1'b0, 1'b1);
    chk("drain", int'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(4'(i + 3), 4'b1110, 1'b1, 1'b1);
      chk("stream_valid", int'(out_valid), 1);
      chk("stream_y", int'(y), int'(4'(i + 3) & 4'b1110));
    end
    cyc(4'b1010, 4'b1100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0101, 4'b0011, 1'b1, 1'b0);
      chk("bp_y", int'(y), 8);
      chk("bp_ready", int'(in_ready), 0);
    end
    cyc(4'b0101, 4'b0011, 1'b1, 1'b1);
    chk("bp_release", int'(y), 1);
    cyc(4'b0110, 4'b1001, 1'b1, 1'b1);
    chk("sim_valid", int'(out_valid), 1);
    chk("sim_y", int'(y), 0);
    cyc(4'b1111, 4'b0111, 1'b1, 1'b0);
    chk("pre_rst_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_y", int'(y), 0);
    chk("arst_zero", int'(y_zero), 1);
    chk("arst_pop", int'(y_pop), 0);
    chk("arst_ready", int'(in_ready), 1);
    q.delete();
    m_y = '0;
    n_acc = 0; n_cons = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1000; i++)
      cyc(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    cyc(4'b0, 4'b0, 1'b0, 1'b1);
    chk("all_consumed", n_acc, n_cons);
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/and4_unit.md
Name: and4_unit

Overview:
- Registered bitwise AND unit for the four-bit ALU datapath. It computes y = a & b over WIDTH bits.
- One valid/ready pipeline stage sits between operand capture and the ALU result mux.
- Registered status flags (zero, all-ones, population count) are produced with each result for downstream flag logic.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..32.
- POPW, $clog2(WIDTH+1), width of the popcount output; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronised externally.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- in_valid  input  1  operands valid this cycle.
- in_ready  output  1  unit accepts operands this cycle.
- y  output  WIDTH  registered result, a & b.
- y_zero  output  1  registered flag; 1 when y == 0.
- y_ones  output  1  registered flag; 1 when y is all ones.
- y_pop  output  POPW  registered count of 1 bits in y.
- out_valid  output  1  result registers hold an unconsumed result.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, y=0, y_zero=1, y_ones=0, y_pop=0.
  - Reset mid-operation discards any held result.
- Readiness: in_ready = !out_valid || out_ready. This is combinational, with no path from in_valid.
- Accept: when in_valid && in_ready at a rising edge, the unit captures:
  - y <= a & b (bitwise, every bit independent)
  - y_zero <= ((a&b) == 0)
  - y_ones <= ((a&b) == all ones)
  - y_pop <= popcount(a&b)
  - out_valid <= 1
- Latency: exactly 1 cycle from accept to out_valid. Throughput: 1 result per cycle while out_ready=1.
- Consume: out_valid && out_ready with no new accept at that edge sets out_valid <= 0. y and flags hold their last values.
- Simultaneous consume and accept: the new result replaces the old one in the same edge and out_valid stays 1. There is no bubble.
- Backpressure: out_valid=1 with out_ready=0 holds y, the flags and out_valid stable. in_ready=0, and a/b are ignored.
- in_valid=0: registers hold; out_valid follows the consume rule only.
- Flags always describe the current y; they are never updated without y.
- X on a/b while not accepted must not propagate into the registers.
- All outputs are driven directly from flops except in_ready.

Decomposition:
- Shared package alu_pkg:
  - ALU_WIDTH=4
  - an alu_flags_t struct {zero, ones, pop}
  - function popcount(logic [WIDTH-1:0])
- Natural sub-module: and_core, purely combinational, computing a&b and the three flag values.
- and4_unit wraps and_core with the handshake register.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> immediately out_valid=0, y=0000, y_zero=1, y_pop=0; in_ready=1 after reset.
- Vectors, each with out_ready=1, and y one cycle after accept:
  - 1111&1111 -> y=1111, y_ones=1, y_pop=4
  - 1010&1100 -> 1000, pop=1
  - 0110&1001 -> 0000, y_zero=1
  - 1111&0000 -> 0000
  - 0000&1111 -> 0000
  - 0101&0011 -> 0001, pop=1
- Back-to-back streaming: in_valid=1 for 6 cycles, out_ready=1 -> 6 consecutive out_valid cycles, results in order, no bubbles.
- Backpressure: hold out_ready=0 after accepting 1010&1100 -> y stays 1000 and in_ready=0. New operands 0101&0011 are ignored until out_ready=1, then accepted next edge -> 0001.
- Simultaneous consume and accept: out_valid=1, out_ready=1, in_valid=1 with 0110&1001 -> out_valid stays 1, y=0000 next cycle.
- Randomised: 1000 random a/b with random valid/ready toggling -> every accepted pair appears exactly once in order. Each result satisfies y==a&b, and its flags match popcount, zero and all-ones.
